multiword_adder: RTL
====================

MULTIWORD_ADDER -- requirements
Module: multiword_adder

Interface
REQ-001 SHALL have parameter SIZE, default 4: chunk width in bits; the adder datapath processes one chunk per cycle.
REQ-002 SHALL have parameter CHUNKS, default 4: number of chunks; total operand width W = SIZE*CHUNKS.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: operand set valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts operands.
REQ-007 SHALL have ports a and b, input, W bits each: operands.
REQ-008 SHALL have port ci, input, 1 bit: carry-in to chunk 0.
REQ-009 SHALL have port out_valid, output, 1 bit: result valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts result.
REQ-011 SHALL have port sum, output, W bits: result.
REQ-012 SHALL have port co, output, 1 bit: carry-out of the top chunk.
REQ-013 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 IDLE SHALL drive in_ready=1; in_valid=1 at an edge latches a, b, ci, sets chunk index to 0 and enters RUN.
REQ-016 in_ready SHALL be 0 in RUN and DONE; in_valid is ignored there.
REQ-017 In RUN, each edge SHALL add chunk[idx] of a and b plus the carry register, write sum chunk[idx], load the carry register with the chunk carry-out, and increment idx.
REQ-018 The carry register SHALL be loaded from ci on acceptance; chunk carry-out SHALL be the (SIZE+1)-th bit of the chunk sum.
REQ-019 At the edge processing idx = CHUNKS-1, the FSM SHALL enter DONE, and co SHALL take the final carry.
REQ-020 out_valid SHALL be 1 only in DONE, exactly CHUNKS edges after the accepting edge; the latency is fixed and independent of the data.
REQ-021 In DONE, sum and co SHALL hold stable until out_ready=1; at that edge the FSM SHALL return to IDLE.
REQ-022 Acceptance and output handshakes SHALL never occur in the same cycle; minimum throughput is one result per CHUNKS+2 cycles.
REQ-023 Carry SHALL wrap with no saturation: sum = (a+b+ci) mod 2^W, and co = bit W of the full sum.
REQ-024 CHUNKS=1 SHALL work, with RUN lasting one cycle.

Reset
REQ-025 rst=1 SHALL immediately force state IDLE, idx=0, the carry register to 0, sum=0, co=0, out_valid=0 and busy=0; in_ready=1 once rst deasserts.
REQ-026 Reset during RUN or DONE SHALL discard the operation with no partial result visible.

Configuration
REQ-027 Macro MULTIWORD_ADDER_SUB_EN SHALL, when defined, add input port sub (1 bit), latched on acceptance.
REQ-028 With the macro defined and sub=1, the block SHALL use ~b and force the initial carry to 1, ignoring ci, giving a-b; co=1 means no borrow.
REQ-029 Without the macro, port sub and all inversion logic SHALL be absent, and the behaviour SHALL be addition only.

Structure
REQ-030 Package multiword_adder_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the default SIZE/CHUNKS constants.
REQ-031 The per-chunk combinational adder SHALL be sub-module chunk_add (SIZE-bit a, b, ci in; sum, co out), instantiated once and time-multiplexed.
REQ-032 The chunk index width SHALL be clog2(CHUNKS), with a minimum of 1.

Verification (SIZE=4, CHUNKS=4)
REQ-033 Scenario: a=0x00FF, b=0x0001, ci=0 -> sum=0x0100, co=0, out_valid exactly 4 edges after acceptance.
REQ-034 Scenario: a=0xFFFF, b=0x0001, ci=0 -> sum=0x0000, co=1, with the carry rippling through all chunks.
REQ-035 Scenario: a=0x1234, b=0x1111, ci=1 -> sum=0x2346, co=0; in_valid pulsed during RUN is not accepted.
REQ-036 Scenario: out_ready=0 for 5 cycles in DONE -> sum and co stable, out_valid held; release -> IDLE with in_ready=1 next cycle.
REQ-037 Scenario: rst asserted at the 2nd RUN cycle -> all outputs 0 immediately; a new operation then completes correctly.
REQ-038 Scenario: with MULTIWORD_ADDER_SUB_EN defined, sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, co=0; a=0x0007, b=0x0005 -> sum=0x0002, co=1.

Source files
------------

// File: rtl/multiword_adder_pkg.sv
// Shared types and defaults for the chunk-serial multiword adder.
// Holds the FSM state encoding and default geometry.
package multiword_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_SIZE   = 4;
  localparam int DEF_CHUNKS = 4;

endpackage

// File: rtl/multiword_adder_chunk_add.sv
// One SIZE-bit slice of the adder, time-multiplexed by the top.
// Carry-out is bit SIZE of the widened slice sum.
module chunk_add #(
  parameter int SIZE = 4
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            ci,
  output logic [SIZE-1:0] sum,
  output logic            co
);

  // widened add so the carry lands in the top bit
  assign {co, sum} = {1'b0, a} + {1'b0, b} + {{SIZE{1'b0}}, ci};

endmodule

// File: rtl/multiword_adder.sv
// Chunk-serial W-bit adder: one SIZE-bit chunk per cycle, fixed latency.
// Optional subtract mode: define MULTIWORD_ADDER_SUB_EN to add port sub.
module multiword_adder
  import multiword_adder_pkg::*;
#(
  parameter int SIZE   = DEF_SIZE,
  parameter int CHUNKS = DEF_CHUNKS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SIZE*CHUNKS-1:0] a,
  input  logic [SIZE*CHUNKS-1:0] b,
  input  logic                   ci,
`ifdef MULTIWORD_ADDER_SUB_EN
  input  logic                   sub,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SIZE*CHUNKS-1:0] sum,
  output logic                   co,
  output logic                   busy
);

  localparam int W  = SIZE * CHUNKS;
  localparam int IW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IW-1:0] LAST = IW'(CHUNKS - 1);
  localparam logic [31:0]   SZ   = 32'(SIZE);

  state_t          state_q;
  state_t          state_d;
  logic [IW-1:0]   idx;
  logic            cy;
  logic [W-1:0]    ra;
  logic [W-1:0]    rb;
  logic [W-1:0]    sum_q;
  logic            co_q;
  logic [31:0]     off;
  logic [SIZE-1:0] ca;
  logic [SIZE-1:0] cb;
  logic [SIZE-1:0] cs;
  logic            cc;
  logic            last;

  assign off  = 32'(idx) * SZ;
  assign ca   = ra[off +: SIZE];
  assign cb   = rb[off +: SIZE];
  assign last = (idx == LAST);

  chunk_add #(
    .SIZE(SIZE)
  ) u_chunk (
    .a  (ca),
    .b  (cb),
    .ci (cy),
    .sum(cs),
    .co (cc)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next-state: accept in IDLE, walk chunks in RUN, hold in DONE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // datapath: latch operands, then one chunk per RUN cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= '0;
      cy    <= 1'b0;
      ra    <= '0;
      rb    <= '0;
      sum_q <= '0;
      co_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            ra    <= a;
`ifdef MULTIWORD_ADDER_SUB_EN
            rb    <= b ^ {W{sub}};
            cy    <= sub | ci;
`else
            rb    <= b;
            cy    <= ci;
`endif
            idx   <= '0;
            sum_q <= '0;
            co_q  <= 1'b0;
          end
        end
        RUN: begin
          sum_q[off +: SIZE] <= cs;
          cy  <= cc;
          idx <= last ? '0 : idx + IW'(1);
          if (last) co_q <= cc;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign co        = co_q;

endmodule
